// File: rtl/zap_memory_align_pipe.sv
// Memory/writeback buffer stage: byte/half/word load extraction at any offset on a
// BUS_WDT read bus, with a two-beat split FSM for loads that straddle a bus word.
module zap_memory_align_pipe #(
  parameter int BUS_WDT  = 32,
  parameter int FLAG_WDT = 32,
  parameter int PHY_REGS = 46
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_code_stall,
  input  logic                        i_clear_from_writeback,
  input  logic                        i_data_stall,
  input  logic                        i_dav_ff,
  input  logic                        i_mem_load_ff,
  input  logic [31:0]                 i_mem_address_ff,
  input  logic [1:0]                  i_size_ff,
  input  logic                        i_signed_ff,
  input  logic [BUS_WDT-1:0]          i_mem_rd_data,
  input  logic                        i_mem_ack,
  input  logic                        i_mem_fault,
  input  logic [31:0]                 i_alu_result_ff,
  input  logic [FLAG_WDT-1:0]         i_flags_ff,
  input  logic [31:0]                 i_pc_plus_8_ff,
  input  logic [$clog2(PHY_REGS)-1:0] i_destination_index_ff,
  input  logic [$clog2(PHY_REGS)-1:0] i_mem_srcdest_index_ff,
  input  logic [31:0]                 i_mem_srcdest_value_ff,
  input  logic                        i_irq_ff,
  input  logic                        i_fiq_ff,
  input  logic                        i_swi_ff,
  input  logic                        i_instr_abort_ff,
  input  logic                        i_und_ff,
  output logic                        o_split_req,
  output logic [31:0]                 o_split_address,
  output logic                        o_busy,
  output logic                        o_dav_ff,
  output logic [31:0]                 o_alu_result_ff,
  output logic [FLAG_WDT-1:0]         o_flags_ff,
  output logic [31:0]                 o_pc_plus_8_ff,
  output logic [$clog2(PHY_REGS)-1:0] o_destination_index_ff,
  output logic [$clog2(PHY_REGS)-1:0] o_mem_srcdest_index_ff,
  output logic                        o_mem_load_ff,
  output logic [31:0]                 o_mem_rd_data,
  output logic                        o_mem_fault,
  output logic                        o_irq_ff,
  output logic                        o_fiq_ff,
  output logic                        o_swi_ff,
  output logic                        o_instr_abort_ff,
  output logic                        o_und_ff
);

  localparam int          OFFW    = $clog2(BUS_WDT / 8);
  localparam logic [7:0]  B_BYTES = 8'(BUS_WDT / 8);

  typedef enum logic [1:0] {IDLE, SPLIT, DONE} state_t;

  state_t              state_q;
  logic                split_req_q;
  logic [BUS_WDT-1:0]  hold_beat0_q;
  logic [OFFW-1:0]     hold_off_q;
  logic [1:0]          hold_size_q;
  logic                hold_signed_q;
  logic                hold_fault_q;
  logic [4:0]          hold_exc_q;

  logic [OFFW-1:0]     off_d;
  logic [7:0]          n_bytes_d;
  logic                split_start_d;
  logic [31:0]         split_addr_d;

  // Little-endian window {beat1, beat0}: take n bytes at off, then extend.
  function automatic logic [31:0] extract(input logic [2*BUS_WDT-1:0] win,
                                          input logic [OFFW-1:0] off,
                                          input logic [1:0] size,
                                          input logic sgn);
    logic [2*BUS_WDT-1:0] sh;
    logic [31:0]          raw;
    sh  = win >> {off, 3'b000};
    raw = sh[31:0];
    case (size)
      2'd0:    extract = sgn ? {{24{raw[7]}}, raw[7:0]}   : {24'h0, raw[7:0]};
      2'd1:    extract = sgn ? {{16{raw[15]}}, raw[15:0]} : {16'h0, raw[15:0]};
      default: extract = raw;
    endcase
  endfunction

  always_comb begin
    off_d = i_mem_address_ff[OFFW-1:0];
    case (i_size_ff)
      2'd0:    n_bytes_d = 8'd1;
      2'd1:    n_bytes_d = 8'd2;
      default: n_bytes_d = 8'd4;
    endcase
    split_start_d = i_dav_ff & i_mem_load_ff & ((8'(off_d) + n_bytes_d) > B_BYTES);
    split_addr_d  = {i_mem_address_ff[31:OFFW], {OFFW{1'b0}}} + 32'(B_BYTES);
  end

  // The request pulse is withdrawn in the very cycle a flush (or reset) arrives.
  assign o_split_req = split_req_q & ~i_reset & ~(i_clear_from_writeback & ~i_code_stall);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q          <= IDLE;
      split_req_q      <= 1'b0;
      o_busy           <= 1'b0;
      o_dav_ff         <= 1'b0;
      o_mem_fault      <= 1'b0;
      o_irq_ff         <= 1'b0;
      o_fiq_ff         <= 1'b0;
      o_swi_ff         <= 1'b0;
      o_instr_abort_ff <= 1'b0;
      o_und_ff         <= 1'b0;
    end else if (i_code_stall) begin
      state_q <= state_q;
    end else if (i_clear_from_writeback) begin
      state_q          <= IDLE;
      split_req_q      <= 1'b0;
      o_busy           <= 1'b0;
      o_dav_ff         <= 1'b0;
      o_mem_fault      <= 1'b0;
      o_irq_ff         <= 1'b0;
      o_fiq_ff         <= 1'b0;
      o_swi_ff         <= 1'b0;
      o_instr_abort_ff <= 1'b0;
      o_und_ff         <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_data_stall) begin
            o_dav_ff <= 1'b0;
          end else begin
            o_alu_result_ff        <= i_alu_result_ff;
            o_flags_ff             <= i_flags_ff;
            o_pc_plus_8_ff         <= i_pc_plus_8_ff;
            o_destination_index_ff <= i_destination_index_ff;
            o_mem_srcdest_index_ff <= i_mem_srcdest_index_ff;
            o_mem_load_ff          <= i_mem_load_ff;
            if (split_start_d) begin
              // Sideband parks in the output registers; exceptions wait for DONE.
              state_q          <= SPLIT;
              split_req_q      <= 1'b1;
              o_split_address  <= split_addr_d;
              o_busy           <= 1'b1;
              o_dav_ff         <= 1'b0;
              o_mem_fault      <= 1'b0;
              o_irq_ff         <= 1'b0;
              o_fiq_ff         <= 1'b0;
              o_swi_ff         <= 1'b0;
              o_instr_abort_ff <= 1'b0;
              o_und_ff         <= 1'b0;
              hold_beat0_q     <= i_mem_rd_data;
              hold_off_q       <= off_d;
              hold_size_q      <= i_size_ff;
              hold_signed_q    <= i_signed_ff;
              hold_fault_q     <= i_mem_fault;
              hold_exc_q       <= {i_irq_ff, i_fiq_ff, i_swi_ff, i_instr_abort_ff, i_und_ff};
            end else begin
              o_dav_ff         <= i_dav_ff;
              o_mem_fault      <= i_dav_ff & i_mem_load_ff & i_mem_fault;
              o_irq_ff         <= i_irq_ff;
              o_fiq_ff         <= i_fiq_ff;
              o_swi_ff         <= i_swi_ff;
              o_instr_abort_ff <= i_instr_abort_ff;
              o_und_ff         <= i_und_ff;
              o_mem_rd_data    <= i_mem_load_ff
                                  ? extract({{BUS_WDT{1'b0}}, i_mem_rd_data}, off_d,
                                            i_size_ff, i_signed_ff)
                                  : i_mem_srcdest_value_ff;
            end
          end
        end
        SPLIT: begin
          split_req_q <= 1'b0;
          if (i_mem_ack) begin
            state_q       <= DONE;
            o_dav_ff      <= 1'b1;
            o_mem_fault   <= hold_fault_q | i_mem_fault;
            o_mem_rd_data <= extract({i_mem_rd_data, hold_beat0_q}, hold_off_q,
                                     hold_size_q, hold_signed_q);
            {o_irq_ff, o_fiq_ff, o_swi_ff, o_instr_abort_ff, o_und_ff} <= hold_exc_q;
          end
        end
        default: begin
          state_q          <= IDLE;
          o_busy           <= 1'b0;
          o_dav_ff         <= 1'b0;
          o_mem_fault      <= 1'b0;
          o_irq_ff         <= 1'b0;
          o_fiq_ff         <= 1'b0;
          o_swi_ff         <= 1'b0;
          o_instr_abort_ff <= 1'b0;
          o_und_ff         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/zap_memory_align_pipe.md
Name: zap_memory_align_pipe

Overview:
- Parametrised successor to the core's memory/writeback buffer stage; sits between the ALU stage and the register file.
- Read bus width is generalised to BUS_WDT. Byte/half/word loads are extracted at any byte offset, with sign or zero extension.
- Adds a two-beat split-load FSM for accesses that straddle a bus-word boundary; the stage stalls upstream while the second beat is fetched.
- Passes ALU result, flags, PC and exception vectors down the pipe as in the existing stage.

Parameters:
- BUS_WDT, 32, read data bus width in bits; legal values 32, 64, 128.
- FLAG_WDT, 32, CPSR width.
- PHY_REGS, 46, physical register count; index width is $clog2(PHY_REGS).

Ports:
- i_clk  in  1  core clock
- i_reset  in  1  reset, synchronous, active-high
- i_code_stall  in  1  freeze every register, including FSM state
- i_clear_from_writeback  in  1  flush stage
- i_data_stall  in  1  upstream data stall
- i_dav_ff  in  1  input instruction valid
- i_mem_load_ff  in  1  instruction is a load
- i_mem_address_ff  in  32  byte address
- i_size_ff  in  2  access size: 0 byte, 1 half, 2 word, 3 reserved (treated as word)
- i_signed_ff  in  1  sign-extend byte/half
- i_mem_rd_data  in  BUS_WDT  bus read beat
- i_mem_ack  in  1  beat valid on i_mem_rd_data
- i_mem_fault  in  1  fault on current beat
- i_alu_result_ff  in  32  ALU result
- i_flags_ff  in  FLAG_WDT  flags
- i_pc_plus_8_ff  in  32  PC+8
- i_destination_index_ff  in  $clog2(PHY_REGS)  ALU destination register
- i_mem_srcdest_index_ff  in  $clog2(PHY_REGS)  load target register
- i_mem_srcdest_value_ff  in  32  pass-through value for non-loads
- i_irq_ff, i_fiq_ff, i_swi_ff, i_instr_abort_ff, i_und_ff  in  1 each  exception vectors
- o_split_req  out  1  request second beat (one-cycle pulse)
- o_split_address  out  32  aligned address of the second beat
- o_busy  out  1  stall upstream while split is in progress
- o_dav_ff  out  1  output valid
- o_alu_result_ff  out  32  registered ALU result
- o_flags_ff  out  FLAG_WDT  registered flags
- o_pc_plus_8_ff  out  32  registered PC+8
- o_destination_index_ff  out  $clog2(PHY_REGS)  registered ALU destination
- o_mem_srcdest_index_ff  out  $clog2(PHY_REGS)  registered load target
- o_mem_load_ff  out  1  registered load flag
- o_mem_rd_data  out  32  extracted/extended load data, or srcdest value for non-loads
- o_mem_fault  out  1  fault on either beat
- o_irq_ff, o_fiq_ff, o_swi_ff, o_instr_abort_ff, o_und_ff  out  1 each  registered exception vectors

Behaviour:
- Notation: B = BUS_WDT/8; off = addr mod B; n = 1, 2 or 4 bytes per i_size_ff.
- Reset: o_dav_ff, o_split_req, o_busy, o_mem_fault and all exception outputs are 0; FSM goes to IDLE. Data outputs are don't-care.
- Priority: reset > code_stall (hold everything) > clear > split FSM > data_stall > normal capture.
- Clear: same as reset for valid, exception and fault outputs; FSM aborts to IDLE; o_split_req drops the same cycle.
- data_stall in IDLE: o_dav_ff <= 0; other outputs hold.

FSM states:
- IDLE
  - Normal capture, one-cycle latency.
  - If i_dav_ff & i_mem_load_ff & off+n > B:
    - capture beat0 (all sideband) into a hold register;
    - go to SPLIT;
    - o_split_req = 1 next cycle, with o_split_address = (addr & ~(B-1)) + B (32-bit wrap);
    - o_dav_ff <= 0.
- SPLIT
  - o_busy = 1 and o_dav_ff = 0; o_split_req is high only on the first SPLIT cycle.
  - On i_mem_ack: capture beat1, OR its fault into the held fault, go to DONE.
  - data_stall is ignored in this state.
- DONE
  - Output the combined load with o_dav_ff = 1 for one cycle.
  - Go to IDLE with o_busy = 0; the next instruction is accepted on the following cycle.

Extraction:
- Form a 2*B-byte little-endian window {beat1, beat0}; beat1 = 0 for non-split loads.
- Take n bytes starting at byte off.
- Sign-extend if i_signed_ff and n < 4; otherwise zero-extend.
- Non-load: o_mem_rd_data = srcdest value unmodified, regardless of size/signed.

Fault and boundary rules:
- o_mem_fault = fault(beat0) | fault(beat1).
- A fault on beat0 of a split still fetches beat1, so the request sequence stays deterministic.
- Address 0xFFFF_FFFF word split: o_split_address wraps to 0x0000_0000.
- An exception vector on a split load is carried through and is presented in DONE.

Test Plan:
- BUS_WDT=32, LDRB signed, addr 0x1003, data 0x80_00_00_00 -> o_mem_rd_data 0xFFFFFF80, dav one cycle after the input.
- BUS_WDT=64, LDRH unsigned, addr 0x100E, data beat 0xBEEF_0000_0000_0000 -> 0x0000BEEF, no split.
- BUS_WDT=32, LDR addr 0x2002:
  - expect o_split_req with address 0x2004 and o_busy = 1;
  - beat0 0xAABB_CCDD, beat1 0x1122_3344 -> o_mem_rd_data 0x3344AABB.
- Split load with i_clear_from_writeback in SPLIT -> FSM to IDLE, o_split_req/o_busy = 0, no dav.
- Split load with fault on beat1 only -> o_mem_fault 1 with dav in DONE; i_data_stall during SPLIT has no effect.
- Reset asserted mid-SPLIT -> all valid/fault/exception outputs 0 next cycle. Non-load with size 0 and value 0x12345678 -> passes 0x12345678 unchanged.
